// File: rtl/bulls_cows_multi.sv
// N-player, N-digit Bulls & Cows game controller with guess validation, round limit/draw and turn rotation.
// Optional build macro DECIMAL_ONLY_EN: digits above 9 are rejected in addition to repeated digits.
module bulls_cows_multi #(
    parameter int NDIG       = 4,
    parameter int NPLAYERS   = 2,
    parameter int MAX_ROUNDS = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [4*NDIG-1:0]           sw,
    input  logic                        enter,
    output logic [2:0]                  state_o,
    output logic [$clog2(NPLAYERS)-1:0] player_o,
    output logic [$clog2(NDIG+1)-1:0]   bulls_o,
    output logic [$clog2(NDIG+1)-1:0]   cows_o,
    output logic [7:0]                  round_o,
    output logic [NPLAYERS-1:0]         winner_o,
    output logic                        err_o,
    output logic                        game_over_o
);

    localparam int PW = $clog2(NPLAYERS);
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [PW-1:0] LAST = PW'(NPLAYERS - 1);

`ifdef DECIMAL_ONLY_EN
    localparam bit DECIMAL_ONLY = 1'b1;
`else
    localparam bit DECIMAL_ONLY = 1'b0;
`endif

    typedef enum logic [2:0] {
        SETUP  = 3'd0,
        GUESS  = 3'd1,
        EVAL   = 3'd2,
        RESULT = 3'd3,
        WIN    = 3'd4,
        DRAW   = 3'd5
    } state_t;

    state_t              state;
    logic                enter_q;
    logic [4*NDIG-1:0]   secret [NPLAYERS];
    logic [4*NDIG-1:0]   guess;
    logic [PW-1:0]       player;
    logic [PW-1:0]       target;
    logic [CW-1:0]       bulls;
    logic [CW-1:0]       cows;
    logic [7:0]          round;
    logic [7:0]          next_round;
    logic [NPLAYERS-1:0] winner;
    logic                err;
    logic                rise;
    logic                valid;
    logic [CW-1:0]       bull_cnt;
    logic [CW-1:0]       cow_cnt;

    assign rise       = enter & ~enter_q;
    assign target     = (player == LAST) ? '0 : player + PW'(1);
    assign next_round = (round == 8'hFF) ? round : round + 8'd1;

    always_comb begin
        valid = 1'b1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (DECIMAL_ONLY && (sw[4*i +: 4] > 4'd9))
                valid = 1'b0;
            for (int unsigned j = i + 1; j < NDIG; j++)
                if (sw[4*i +: 4] == sw[4*j +: 4])
                    valid = 1'b0;
        end
    end

    // Player p is always scored against the secret of the next player in rotation.
    always_comb begin
        bull_cnt = '0;
        cow_cnt  = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            for (int unsigned j = 0; j < NDIG; j++) begin
                if (secret[target][4*i +: 4] == guess[4*j +: 4]) begin
                    if (i == j) bull_cnt = bull_cnt + CW'(1);
                    else        cow_cnt  = cow_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= SETUP;
            enter_q <= 1'b0;
            guess   <= '0;
            player  <= '0;
            bulls   <= '0;
            cows    <= '0;
            round   <= '0;
            winner  <= '0;
            err     <= 1'b0;
            for (int unsigned p = 0; p < NPLAYERS; p++)
                secret[p] <= '0;
        end else begin
            enter_q <= enter;
            err     <= 1'b0;
            case (state)
                SETUP: if (rise) begin
                    if (valid) begin
                        secret[player] <= sw;
                        if (player == LAST) begin
                            state  <= GUESS;
                            player <= '0;
                        end else begin
                            player <= player + PW'(1);
                        end
                    end else begin
                        err <= 1'b1;
                    end
                end
                GUESS: if (rise) begin
                    if (valid) begin
                        guess <= sw;
                        state <= EVAL;
                    end else begin
                        err <= 1'b1;
                    end
                end
                EVAL: begin
                    bulls <= bull_cnt;
                    cows  <= cow_cnt;
                    if (bull_cnt == CW'(NDIG)) begin
                        state  <= WIN;
                        winner <= {{(NPLAYERS-1){1'b0}}, 1'b1} << player;
                    end else begin
                        state <= RESULT;
                    end
                end
                RESULT: if (rise) begin
                    if (player == LAST) begin
                        player <= '0;
                        round  <= next_round;
                        if ((MAX_ROUNDS != 0) && (next_round == 8'(MAX_ROUNDS)))
                            state <= DRAW;
                        else
                            state <= GUESS;
                    end else begin
                        player <= player + PW'(1);
                        state  <= GUESS;
                    end
                end
                WIN, DRAW: if (rise) begin
                    state  <= SETUP;
                    player <= '0;
                    bulls  <= '0;
                    cows   <= '0;
                    round  <= '0;
                    winner <= '0;
                    for (int unsigned p = 0; p < NPLAYERS; p++)
                        secret[p] <= '0;
                end
                default: state <= SETUP;
            endcase
        end
    end

    assign state_o     = state;
    assign player_o    = player;
    assign bulls_o     = bulls;
    assign cows_o      = cows;
    assign round_o     = round;
    assign winner_o    = winner;
    assign err_o       = err;
    assign game_over_o = (state == WIN) || (state == DRAW);

endmodule

// File: tb/tb_bulls_cows_multi.sv
// Scoreboard bench for bulls_cows_multi (NDIG=4, NPLAYERS=2, MAX_ROUNDS=2) with hand-computed expectations.
module tb_bulls_cows_multi;

    localparam logic [2:0] S_SETUP = 3'd0, S_GUESS = 3'd1, S_EVAL = 3'd2,
                           S_RESULT = 3'd3, S_WIN = 3'd4, S_DRAW = 3'd5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sw    = '0;
    logic        enter = 1'b0;
    logic [2:0]  state_o;
    logic        player_o;
    logic [2:0]  bulls_o;
    logic [2:0]  cows_o;
    logic [7:0]  round_o;
    logic [1:0]  winner_o;
    logic        err_o;
    logic        game_over_o;

    bulls_cows_multi #(.NDIG(4), .NPLAYERS(2), .MAX_ROUNDS(2)) dut (
        .clock(clock), .reset(reset), .sw(sw), .enter(enter),
        .state_o(state_o), .player_o(player_o), .bulls_o(bulls_o), .cows_o(cows_o),
        .round_o(round_o), .winner_o(winner_o), .err_o(err_o), .game_over_o(game_over_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic       pl;
        logic [2:0] b;
        logic [2:0] c;
        logic [7:0] rd;
        logic [1:0] win;
        logic       err;
        logic       go;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    mon_en = 1'b0;
    bit    probe  = 1'b0;

    function automatic snap_t mk(input logic [2:0] st, input logic pl, input logic [2:0] b,
                                 input logic [2:0] c, input logic [7:0] rd, input logic [1:0] win,
                                 input logic err, input logic go);
        snap_t s;
        s = '{st: st, pl: pl, b: b, c: c, rd: rd, win: win, err: err, go: go};
        return s;
    endfunction

    task automatic expect_snap(input string nm, input snap_t s);
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    task automatic press(input logic [15:0] v);
        @(negedge clock);
        sw    = v;
        enter = 1'b1;
        @(negedge clock);
        enter = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        @(negedge clock);
        sw    = v;
        enter = 1'b1;
        repeat (n) @(negedge clock);
        enter = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    // Monitor: pops one expectation whenever state/player changes, err pulses, or a probe is requested.
    initial begin : monitor
        logic [2:0] prev_st;
        logic       prev_pl;
        snap_t      act;
        snap_t      e;
        string      nm;
        wait (mon_en);
        prev_st = state_o;
        prev_pl = player_o;
        forever begin
            @(negedge clock);
            if (probe || state_o != prev_st || player_o != prev_pl || err_o) begin
                probe = 1'b0;
                act = '{st: state_o, pl: player_o, b: bulls_o, c: cows_o, rd: round_o,
                        win: winner_o, err: err_o, go: game_over_o};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got st=%0d pl=%0d b=%0d c=%0d rd=%0d win=%b err=%b go=%b, required nothing",
                             act.st, act.pl, act.b, act.c, act.rd, act.win, act.err, act.go);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL %s: got st=%0d pl=%0d b=%0d c=%0d rd=%0d win=%b err=%b go=%b, required st=%0d pl=%0d b=%0d c=%0d rd=%0d win=%b err=%b go=%b",
                                 nm, act.st, act.pl, act.b, act.c, act.rd, act.win, act.err, act.go,
                                 e.st, e.pl, e.b, e.c, e.rd, e.win, e.err, e.go);
                    end
                end
            end
            prev_st = state_o;
            prev_pl = player_o;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;
        expect_snap("reset_state", mk(S_SETUP, 0, 0, 0, 0, 2'b00, 0, 0));
        probe = 1'b1;
        repeat (2) @(negedge clock);

        // Game A: rejection, evaluation, held enter, win and restart
        expect_snap("setup_repeat_reject", mk(S_SETUP, 0, 0, 0, 0, 2'b00, 1, 0));
        press(16'h1123);
        expect_snap("setup_p0", mk(S_SETUP, 1, 0, 0, 0, 2'b00, 0, 0));
        press(16'h1234);
        expect_snap("setup_p1", mk(S_GUESS, 0, 0, 0, 0, 2'b00, 0, 0));
        press(16'h5678);
        expect_snap("guess_repeat_reject", mk(S_GUESS, 0, 0, 0, 0, 2'b00, 1, 0));
        press(16'h5578);
        expect_snap("eval_once_held", mk(S_EVAL, 0, 0, 0, 0, 2'b00, 0, 0));
        expect_snap("result_2b2c", mk(S_RESULT, 0, 2, 2, 0, 2'b00, 0, 0));
        hold(16'h5687, 10);
        expect_snap("rotate_to_p1", mk(S_GUESS, 1, 2, 2, 0, 2'b00, 0, 0));
        press(16'h0000);
        expect_snap("eval_p1", mk(S_EVAL, 1, 2, 2, 0, 2'b00, 0, 0));
        expect_snap("result_0b4c", mk(S_RESULT, 1, 0, 4, 0, 2'b00, 0, 0));
        press(16'h4321);
        expect_snap("wrap_round1", mk(S_GUESS, 0, 0, 4, 1, 2'b00, 0, 0));
        press(16'h0000);
        expect_snap("eval_win_guess", mk(S_EVAL, 0, 0, 4, 1, 2'b00, 0, 0));
        expect_snap("win_p0", mk(S_WIN, 0, 4, 0, 1, 2'b01, 0, 1));
        press(16'h5678);
        expect_snap("restart_from_win", mk(S_SETUP, 0, 0, 0, 0, 2'b00, 0, 0));
        press(16'h1111);

        // Game B: digit range option, then play to the round limit
`ifdef DECIMAL_ONLY_EN
        expect_snap("decimal_reject", mk(S_SETUP, 0, 0, 0, 0, 2'b00, 1, 0));
        press(16'h12A4);
        expect_snap("setup_p0_b", mk(S_SETUP, 1, 0, 0, 0, 2'b00, 0, 0));
        press(16'h1234);
`else
        expect_snap("hex_digit_accept", mk(S_SETUP, 1, 0, 0, 0, 2'b00, 0, 0));
        press(16'h12A4);
`endif
        expect_snap("setup_p1_b", mk(S_GUESS, 0, 0, 0, 0, 2'b00, 0, 0));
        press(16'h5678);
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 2; p++) begin
                expect_snap("eval_miss", mk(S_EVAL, p[0], 0, 0, 8'(r), 2'b00, 0, 0));
                expect_snap("result_miss", mk(S_RESULT, p[0], 0, 0, 8'(r), 2'b00, 0, 0));
                press(p == 0 ? 16'h9012 : 16'h9875);
                if (p == 0)
                    expect_snap("rotate_miss", mk(S_GUESS, 1, 0, 0, 8'(r), 2'b00, 0, 0));
                else if (r == 1)
                    expect_snap("draw_limit", mk(S_DRAW, 0, 0, 0, 8'd2, 2'b00, 0, 1));
                else
                    expect_snap("wrap_miss", mk(S_GUESS, 0, 0, 0, 8'(r + 1), 2'b00, 0, 0));
                press(16'h0000);
            end
        end
        expect_snap("restart_from_draw", mk(S_SETUP, 0, 0, 0, 0, 2'b00, 0, 0));
        press(16'h0000);

        // Game C: reset during EVAL, enter held high across reset release
        expect_snap("setup_p0_c", mk(S_SETUP, 1, 0, 0, 0, 2'b00, 0, 0));
        press(16'h1234);
        expect_snap("setup_p1_c", mk(S_GUESS, 0, 0, 0, 0, 2'b00, 0, 0));
        press(16'h5678);
        expect_snap("eval_before_reset", mk(S_EVAL, 0, 0, 0, 0, 2'b00, 0, 0));
        expect_snap("reset_in_eval", mk(S_SETUP, 0, 0, 0, 0, 2'b00, 0, 0));
        @(negedge clock);
        sw    = 16'h5687;
        enter = 1'b1;
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        sw = 16'h1234;
        expect_snap("held_enter_rise_after_reset", mk(S_SETUP, 1, 0, 0, 0, 2'b00, 0, 0));
        #2 reset = 1'b0;
        repeat (4) @(negedge clock);
        enter = 1'b0;
        repeat (5) @(negedge clock);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_expectations: got %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
